// File: rtl/count_seq_ctrl.sv
// ---------------------------------------------------------------------------
// count_seq_ctrl
//
// Run controller for a WIDTH-bit up-counter. A run loads a start value and
// captures a terminal value. The counter then steps once every DIV clocks
// until it reaches the terminal value. On arrival it raises a one-cycle stop
// pulse and returns to IDLE. A run can be paused (count and prescaler frozen)
// or aborted (return to IDLE with no stop pulse).
//
// Parameters
//   WIDTH        counter width in bits (>= 2)
//   DIV          clocks per count step while running (>= 1)
//
// Ports
//   clk          clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   start_i      begin a run; only looked at in IDLE
//   abort_i      leave RUN/HOLD for IDLE at once, no stop pulse
//   pause_i      level; while high a RUN moves to HOLD and stays there
//   start_val_i  first count value, captured on start
//   term_val_i   terminal count value, captured on start
//   count_o      current count (registered)
//   busy_o       high in RUN or HOLD
//   stop_o       one-cycle pulse while in DONE (count_o == term)
//   wrap_o       one-cycle pulse when a step takes the count from all-ones to 0
// ---------------------------------------------------------------------------
module count_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             pause_i,
    input  logic [WIDTH-1:0] start_val_i,
    input  logic [WIDTH-1:0] term_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             stop_o,
    output logic             wrap_o
);

    // Prescaler needs at least one bit even when DIV == 1; in that case it
    // simply stays at 0 and every RUN cycle is a step cycle.
    localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] term_q,  term_d;
    logic [PW-1:0]    pre_q,   pre_d;
    logic             wrap_q,  wrap_d;

    logic [WIDTH-1:0] count_inc;
    logic             pre_last;

    assign count_inc = count_q + WIDTH'(1);
    assign pre_last  = (pre_q == PS_LAST);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            term_q  <= '0;
            pre_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            term_q  <= term_d;
            pre_q   <= pre_d;
            wrap_q  <= wrap_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        term_d  = term_q;
        pre_d   = pre_q;
        wrap_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // abort/pause have no meaning before a run exists
                if (start_i) begin
                    count_d = start_val_i;
                    term_d  = term_val_i;
                    pre_d   = '0;
                    state_d = (start_val_i == term_val_i) ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (pause_i) begin
                    state_d = S_HOLD;
                end else if (pre_last) begin
                    pre_d   = '0;
                    count_d = count_inc;
                    // all-ones before the step means the new value is 0
                    wrap_d  = &count_q;
                    if (count_inc == term_q) begin
                        state_d = S_DONE;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end

            S_HOLD: begin
                // Resume edge only returns to RUN; the next step is counted
                // from the following RUN cycle.
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (!pause_i) begin
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                // single-cycle state; a start seen here is dropped
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // -----------------------------------------------------------------------
    assign count_o = count_q;
    assign busy_o  = (state_q == S_RUN) || (state_q == S_HOLD);
    assign stop_o  = (state_q == S_DONE);
    assign wrap_o  = wrap_q;

endmodule
